prog_loader: RTL and testbench

Boot-time program loader that receives a framed byte stream from a byte source (UART receiver or similar) and packs it into 32-bit instruction words. It writes those words sequentially into the instruction memory that the processor fetches from. It is the write-side counterpart of the processor's instruction fetch path. It holds the processor in reset (`cpu_hold`) from reset until a complete frame with a correct checksum has been written.

---
 rtl/prog_loader_pkg.sv | 19 +
 rtl/prog_loader_defs.vh | 13 +
 rtl/prog_loader_idle_timer.sv | 42 ++++
 rtl/prog_loader.sv | 182 ++++++++++++++++++
 tb/tb_prog_loader.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/prog_loader_pkg.sv
// Package for the boot program loader: FSM encodings taken from the shared defs and small helpers.
`include "prog_loader_defs.vh"

package prog_loader_pkg;

   localparam logic [2:0] ST_IDLE  = `PL_ST_IDLE;
   localparam logic [2:0] ST_COUNT = `PL_ST_COUNT;
   localparam logic [2:0] ST_DATA  = `PL_ST_DATA;
   localparam logic [2:0] ST_CHECK = `PL_ST_CHECK;
   localparam logic [2:0] ST_ERR   = `PL_ST_ERR;

   localparam logic [7:0] HEADER_DEFAULT = `PL_HEADER_DEFAULT;

   // A count byte of zero encodes a full 256-word image.
   function automatic logic [8:0] word_count(input logic [7:0] c);
      return (c == 8'd0) ? 9'd256 : {1'b0, c};
   endfunction

endpackage

// File: rtl/prog_loader_defs.vh
// Frame loader constants shared with host-side tooling: 3-bit state codes and the default frame header.
`ifndef PROG_LOADER_DEFS_VH
`define PROG_LOADER_DEFS_VH

`define PL_ST_IDLE   3'd0
`define PL_ST_COUNT  3'd1
`define PL_ST_DATA   3'd2
`define PL_ST_CHECK  3'd3
`define PL_ST_ERR    3'd4

`define PL_HEADER_DEFAULT 8'hA5

`endif

// File: rtl/prog_loader_idle_timer.sv
// Inter-byte idle counter; expired flags the TIMEOUT-th consecutive cycle without a clear.
module idle_timer #(
   parameter int unsigned TIMEOUT = 1000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] MAXV  = CW'(TIMEOUT);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   // count_q holds the number of idle cycles already completed, so the cycle that
   // would complete the TIMEOUT-th one is the one that reports expiry.
   assign expired = enable && !clear && (count_q == LIMIT);

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = {CW{1'b0}};
      end else if (enable && (count_q != MAXV)) begin
         count_d = count_q + CW'(1);
      end else begin
         count_d = count_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= {CW{1'b0}};
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/prog_loader.sv
// Boot loader: parses HEADER/count/payload/checksum frames and writes big-endian words into imem.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int unsigned TIMEOUT = 1000000,
   parameter logic [7:0]  HEADER  = HEADER_DEFAULT
) (
   input  logic        clk100,
   input  logic        rst_n,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        imem_we,
   output logic [7:0]  imem_addr,
   output logic [31:0] imem_wdata,
   output logic        cpu_hold,
   output logic        done,
   output logic        err
);

   logic [2:0]  state_q, state_d;
   logic [8:0]  words_q, words_d;
   logic [7:0]  addr_q, addr_d;
   logic [1:0]  byte_idx_q, byte_idx_d;
   logic [23:0] asm_q, asm_d;
   logic [7:0]  xor_q, xor_d;
   logic        in_ready_q;
   logic        imem_we_q, imem_we_d;
   logic [7:0]  imem_addr_q, imem_addr_d;
   logic [31:0] imem_wdata_q, imem_wdata_d;
   logic        cpu_hold_q, cpu_hold_d;
   logic        done_q, done_d;
   logic        err_q, err_d;

   logic        accept_s;
   logic        active_s;
   logic        expired_s;
   logic [31:0] word_s;

   assign accept_s = in_valid && in_ready_q;
   assign active_s = (state_q == ST_COUNT) || (state_q == ST_DATA) || (state_q == ST_CHECK);
   assign word_s   = {asm_q, in_data};

   idle_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_idle_timer (
      .clk     (clk100),
      .rst_n   (rst_n),
      .clear   (accept_s || !active_s),
      .enable  (active_s),
      .expired (expired_s)
   );

   always_comb begin
      state_d      = state_q;
      words_d      = words_q;
      addr_d       = addr_q;
      byte_idx_d   = byte_idx_q;
      asm_d        = asm_q;
      xor_d        = xor_q;
      imem_we_d    = 1'b0;
      imem_addr_d  = imem_addr_q;
      imem_wdata_d = imem_wdata_q;
      cpu_hold_d   = cpu_hold_q;
      done_d       = 1'b0;
      err_d        = err_q;

      case (state_q)
         ST_IDLE, ST_ERR: begin
            if (accept_s && (in_data == HEADER)) begin
               state_d    = ST_COUNT;
               cpu_hold_d = 1'b1;
            end else begin
               state_d = state_q;
            end
         end
         ST_COUNT: begin
            if (accept_s) begin
               words_d    = word_count(in_data);
               addr_d     = 8'd0;
               byte_idx_d = 2'd0;
               xor_d      = 8'd0;
               err_d      = 1'b0;
               state_d    = ST_DATA;
            end else if (expired_s) begin
               err_d   = 1'b1;
               state_d = ST_ERR;
            end else begin
               state_d = ST_COUNT;
            end
         end
         ST_DATA: begin
            if (accept_s) begin
               asm_d      = word_s[23:0];
               xor_d      = xor_q ^ in_data;
               byte_idx_d = byte_idx_q + 2'd1;
               if (byte_idx_q == 2'd3) begin
                  imem_we_d    = 1'b1;
                  imem_addr_d  = addr_q;
                  imem_wdata_d = word_s;
                  addr_d       = addr_q + 8'd1;
                  words_d      = words_q - 9'd1;
                  if (words_q == 9'd1) begin
                     state_d = ST_CHECK;
                  end else begin
                     state_d = ST_DATA;
                  end
               end else begin
                  state_d = ST_DATA;
               end
            end else if (expired_s) begin
               // A partially assembled word is simply dropped.
               err_d   = 1'b1;
               state_d = ST_ERR;
            end else begin
               state_d = ST_DATA;
            end
         end
         ST_CHECK: begin
            if (accept_s) begin
               if (in_data == xor_q) begin
                  done_d     = 1'b1;
                  cpu_hold_d = 1'b0;
                  state_d    = ST_IDLE;
               end else begin
                  err_d   = 1'b1;
                  state_d = ST_ERR;
               end
            end else if (expired_s) begin
               err_d   = 1'b1;
               state_d = ST_ERR;
            end else begin
               state_d = ST_CHECK;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk100 or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         words_q      <= 9'd0;
         addr_q       <= 8'd0;
         byte_idx_q   <= 2'd0;
         asm_q        <= 24'd0;
         xor_q        <= 8'd0;
         in_ready_q   <= 1'b0;
         imem_we_q    <= 1'b0;
         imem_addr_q  <= 8'd0;
         imem_wdata_q <= 32'd0;
         cpu_hold_q   <= 1'b1;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         words_q      <= words_d;
         addr_q       <= addr_d;
         byte_idx_q   <= byte_idx_d;
         asm_q        <= asm_d;
         xor_q        <= xor_d;
         in_ready_q   <= 1'b1;
         imem_we_q    <= imem_we_d;
         imem_addr_q  <= imem_addr_d;
         imem_wdata_q <= imem_wdata_d;
         cpu_hold_q   <= cpu_hold_d;
         done_q       <= done_d;
         err_q        <= err_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign imem_we    = imem_we_q;
   assign imem_addr  = imem_addr_q;
   assign imem_wdata = imem_wdata_q;
   assign cpu_hold   = cpu_hold_q;
   assign done       = done_q;
   assign err        = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: frame loads, checksum error, garbage, 256-word image, timeout, reset.
module tb_prog_loader;

   logic        clk100 = 1'b0;
   logic        rst_n  = 1'b0;
   logic [7:0]  in_data = 8'd0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        imem_we;
   logic [7:0]  imem_addr;
   logic [31:0] imem_wdata;
   logic        cpu_hold;
   logic        done;
   logic        err;

   always #5 clk100 = ~clk100;

   prog_loader #(
      .TIMEOUT (16),
      .HEADER  (8'hA5)
   ) dut (
      .clk100     (clk100),
      .rst_n      (rst_n),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_hold   (cpu_hold),
      .done       (done),
      .err        (err)
   );

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [7:0]  wr_addr_log[$];
   logic [31:0] wr_data_log[$];
   int          done_cnt = 0;

   // Log every write strobe and done cycle seen at the clock edge.
   always @(posedge clk100) begin
      if (imem_we) begin
         wr_addr_log.push_back(imem_addr);
         wr_data_log.push_back(imem_wdata);
      end
      if (done) done_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   task automatic clear_log();
      wr_addr_log.delete();
      wr_data_log.delete();
      done_cnt = 0;
   endtask

   task automatic send(input logic [7:0] b);
      @(negedge clk100);
      in_valid = 1'b1;
      in_data  = b;
   endtask

   task automatic stop();
      @(negedge clk100);
      in_valid = 1'b0;
      in_data  = 8'd0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk100);
   endtask

   // Two-word reference frame; correct checksum is 8'h40.
   task automatic frame1(input logic [7:0] ck);
      send(8'hA5); send(8'h02);
      send(8'h01); send(8'h02); send(8'h03); send(8'h04);
      send(8'h11); send(8'h22); send(8'h33); send(8'h44);
      send(ck);
      stop();
   endtask

   task automatic check_frame1_writes(input string tag);
      check({tag, " wr count"}, wr_addr_log.size(), 2);
      if (wr_addr_log.size() == 2) begin
         check({tag, " addr0"}, wr_addr_log[0], 0);
         check({tag, " data0"}, wr_data_log[0], 32'h01020304);
         check({tag, " addr1"}, wr_addr_log[1], 1);
         check({tag, " data1"}, wr_data_log[1], 32'h11223344);
      end
   endtask

   initial begin
      int bad_seq;

      // Reset state
      #12;
      check("rst in_ready", in_ready, 0);
      check("rst imem_we", imem_we, 0);
      check("rst imem_addr", imem_addr, 0);
      check("rst imem_wdata", imem_wdata, 0);
      check("rst cpu_hold", cpu_hold, 1);
      check("rst done", done, 0);
      check("rst err", err, 0);
      @(negedge clk100);
      rst_n = 1'b1;
      idle(1);
      check("in_ready after rst", in_ready, 1);

      // Good frame, back to back
      clear_log();
      frame1(8'h40);
      check("good done pulse", done, 1);
      check("good cpu_hold", cpu_hold, 0);
      idle(3);
      check_frame1_writes("good");
      check("good done count", done_cnt, 1);
      check("good err", err, 0);
      check("good hold stays low", cpu_hold, 0);

      // New header raises hold again; bad checksum gives err
      clear_log();
      send(8'hA5);
      stop();
      check("hdr raises hold", cpu_hold, 1);
      send(8'h02);
      send(8'h01); send(8'h02); send(8'h03); send(8'h04);
      send(8'h11); send(8'h22); send(8'h33); send(8'h44);
      send(8'h41);
      stop();
      idle(3);
      check_frame1_writes("badck");
      check("badck err", err, 1);
      check("badck hold", cpu_hold, 1);
      check("badck done count", done_cnt, 0);

      // Recovery from ERR
      clear_log();
      frame1(8'h40);
      idle(3);
      check("recover err", err, 0);
      check("recover hold", cpu_hold, 0);
      check("recover done count", done_cnt, 1);
      check_frame1_writes("recover");

      // Leading garbage ignored
      clear_log();
      send(8'h00); send(8'h5A); send(8'hFF);
      stop();
      idle(3);
      check("garbage wr count", wr_addr_log.size(), 0);
      check("garbage err", err, 0);
      check("garbage hold", cpu_hold, 0);
      frame1(8'h40);
      idle(3);
      check_frame1_writes("after garbage");
      check("after garbage done", done_cnt, 1);

      // 256-word image, word value = index, checksum 0
      clear_log();
      send(8'hA5); send(8'h00);
      for (int i = 0; i < 256; i++) begin
         send(8'h00); send(8'h00); send(8'h00); send(8'(i));
      end
      send(8'h00);
      stop();
      idle(3);
      check("big wr count", wr_addr_log.size(), 256);
      if (wr_addr_log.size() == 256) begin
         bad_seq = 0;
         for (int i = 0; i < 256; i++) begin
            if (wr_addr_log[i] !== 8'(i) || wr_data_log[i] !== 32'(i)) bad_seq++;
         end
         check("big seq errors", bad_seq, 0);
         check("big last addr", wr_addr_log[255], 8'hFF);
         check("big last data", wr_data_log[255], 32'h000000FF);
      end
      check("big done count", done_cnt, 1);
      check("big err", err, 0);
      check("big hold", cpu_hold, 0);

      // Timeout: err exactly 16 cycles after last accepted byte
      clear_log();
      send(8'hA5); send(8'h01); send(8'h12); send(8'h34);
      stop();
      idle(15);
      check("timeout err at 15", err, 0);
      idle(1);
      check("timeout err at 16", err, 1);
      check("timeout hold", cpu_hold, 1);
      idle(4);
      check("timeout no write", wr_addr_log.size(), 0);
      check("timeout no done", done_cnt, 0);

      // Reset in the middle of DATA after 6 payload bytes
      clear_log();
      send(8'hA5); send(8'h02);
      send(8'h01); send(8'h02); send(8'h03); send(8'h04);
      send(8'h11); send(8'h22);
      stop();
      rst_n = 1'b0;
      #1;
      check("midrst in_ready", in_ready, 0);
      check("midrst imem_we", imem_we, 0);
      check("midrst imem_addr", imem_addr, 0);
      check("midrst imem_wdata", imem_wdata, 0);
      check("midrst cpu_hold", cpu_hold, 1);
      check("midrst done", done, 0);
      check("midrst err", err, 0);
      idle(3);
      rst_n = 1'b1;
      idle(3);
      check("midrst writes", wr_addr_log.size(), 1);
      clear_log();
      frame1(8'h40);
      idle(3);
      check_frame1_writes("post rst");
      check("post rst done", done_cnt, 1);
      check("post rst hold", cpu_hold, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
